uart_rx_fifo: RTL and testbench

//   Receive buffer placed directly downstream of uart_rx. Captures each completed frame
//   (data byte plus error flag) into a first-word-fall-through FIFO, then presents it to
//   the consumer (LED/echo logic, uart_tx feeder) on a valid/ready stream. Decouples the

---
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: captures completed frames into a first-word-fall-through buffer
// and presents them on a valid/ready stream. Define UART_RX_FIFO_DROP_ERR_EN to discard errored frames.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_ready,
  input  logic [DATA_BITS-1:0]       rx_data,
  input  logic                       rx_error,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_BITS-1:0]       m_data,
  output logic                       m_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam int unsigned EW = DATA_BITS;
`else
  localparam int unsigned EW = DATA_BITS + 1;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          rx_ready_q, rx_ready_d;

  logic          edge_seen;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign edge_seen = rx_ready & ~rx_ready_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Errored frames never reach the FIFO, so they cannot cause an overrun either.
  assign push_req = edge_seen & ~rx_error;
  assign wr_entry = rx_data;
  assign m_err    = 1'b0;
`else
  assign push_req = edge_seen;
  assign wr_entry = {rx_error, rx_data};
  assign m_err    = rd_entry[DATA_BITS];
`endif

  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(ALMOST_FULL));
  assign m_valid     = (count_q != '0);
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign rd_entry    = mem_q[rd_ptr_q];
  assign m_data      = rd_entry[DATA_BITS-1:0];

  assign pop  = m_valid & m_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    rx_ready_d = rx_ready;

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      // Start high so an idle uart_rx holding ready=1 is not taken as a new frame.
      rx_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default depth 16, almost-full at 12).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_error = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_err;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_error   (rx_error),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_err      (m_err),
    .count      (count),
    .full       (full),
    .almost_full(almost_full),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge on rx_ready; the push lands on the first clock edge.
  task automatic push_frame(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    // 1. reset, three frames, drain
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_overrun", 32'(overrun), 0);

    push_frame(8'h41, 1'b0);
    push_frame(8'h42, 1'b0);
    push_frame(8'h43, 1'b0);
    chk("t1_count", 32'(count), 3);
    chk("t1_valid", 32'(m_valid), 1);
    chk("t1_head", 32'(m_data), 32'h41);
    m_ready = 1'b1;
    chk("t1_pop0", 32'(m_data), 32'h41);
    tick();
    chk("t1_pop1", 32'(m_data), 32'h42);
    tick();
    chk("t1_pop2", 32'(m_data), 32'h43);
    tick();
    chk("t1_empty", 32'(m_valid), 0);
    m_ready = 1'b0;

    // 2. fill, overrun, drain, clear
    for (int i = 0; i < 16; i++) begin
      push_frame(8'(i), 1'b0);
      if (i == 10) chk("t2_af_at11", 32'(almost_full), 0);
      if (i == 11) chk("t2_af_at12", 32'(almost_full), 1);
    end
    chk("t2_count16", 32'(count), 16);
    chk("t2_full", 32'(full), 1);
    chk("t2_ovr_before", 32'(overrun), 0);
    push_frame(8'hFF, 1'b0);
    chk("t2_ovr_set", 32'(overrun), 1);
    chk("t2_count_drop", 32'(count), 16);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", 32'(m_data), 32'(i));
      tick();
    end
    m_ready = 1'b0;
    chk("t2_empty", 32'(m_valid), 0);
    chk("t2_ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t2_ovr_clr", 32'(overrun), 0);

    // 3. push and pop together while full
    for (int i = 0; i < 16; i++) push_frame(8'(8'h80 + i), 1'b0);
    chk("t3_full", 32'(full), 1);
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_ready  = 1'b0;
    tick();
    chk("t3_count", 32'(count), 16);
    chk("t3_ovr", 32'(overrun), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", 32'(m_data), (i < 15) ? 32'(8'h81 + i) : 32'hA5);
      tick();
    end
    m_ready = 1'b0;
    chk("t3_empty", 32'(m_valid), 0);

    // 4. errored frame
    push_frame(8'h55, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    chk("t4_count", 32'(count), 0);
    chk("t4_valid", 32'(m_valid), 0);
    chk("t4_ovr", 32'(overrun), 0);
`else
    chk("t4_valid", 32'(m_valid), 1);
    chk("t4_data", 32'(m_data), 32'h55);
    chk("t4_err", 32'(m_err), 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t4_popped", 32'(count), 0);
`endif
    rx_error = 1'b0;

    // 5. ready held high, then reset with entries
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rx_ready = 1'b0;
    tick();
    chk("t5_held", 32'(count), 1);
    for (int i = 0; i < 4; i++) push_frame(8'(i), 1'b0);
    chk("t5_count5", 32'(count), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_valid", 32'(m_valid), 0);
    chk("t5_rst_ovr", 32'(overrun), 0);
    tick();

    // 6. push into empty FIFO with consumer ready
    rx_data  = 8'h11;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    chk("t6_no_bypass", 32'(m_valid), 0);
    tick();
    rx_ready = 1'b0;
    chk("t6_valid", 32'(m_valid), 1);
    chk("t6_data", 32'(m_data), 32'h11);
    tick();
    m_ready = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
